// File: rtl/rmt_ingress_demux_if.sv
// AXI-Stream bundle used for the ingress and both egress ports of the demux.
interface rmt_ingress_demux_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/rmt_ingress_demux.sv
// Ingress demux: classifies each packet on its first beat and steers the
// whole packet to the data output, the control output, or a drop sink.

// One-entry AXIS register stage; one instance per egress port.
module rmt_ingress_demux_ostage #(
  parameter int DW = 512,
  parameter int UW = 128
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [DW-1:0]  in_tdata,
  input  logic [DW/8-1:0] in_tkeep,
  input  logic [UW-1:0]  in_tuser,
  input  logic           in_tlast,
  input  logic           out_tready,
  output logic [DW-1:0]  out_tdata,
  output logic [DW/8-1:0] out_tkeep,
  output logic [UW-1:0]  out_tuser,
  output logic           out_tlast,
  output logic           out_tvalid,
  output logic           can_acc
);
  // Empty, or draining this cycle, so a new beat can be taken.
  assign can_acc = !out_tvalid | out_tready;

  // Load wins over drain so a simultaneous load/drain keeps tvalid high;
  // payload only changes on load, which keeps it stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tuser  <= '0;
      out_tlast  <= 1'b0;
    end else if (load) begin
      out_tvalid <= 1'b1;
      out_tdata  <= in_tdata;
      out_tkeep  <= in_tkeep;
      out_tuser  <= in_tuser;
      out_tlast  <= in_tlast;
    end else if (out_tready) begin
      out_tvalid <= 1'b0;
    end
  end
endmodule

module rmt_ingress_demux #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [15:0] CTRL_UDP_PORT        = 16'hF1F2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ctrl_en,
  rmt_ingress_demux_if.slave         s_axis,
  rmt_ingress_demux_if.master        m_data_axis,
  rmt_ingress_demux_if.master        m_ctrl_axis,
  output logic [31:0]                data_pkt_cnt,
  output logic [31:0]                ctrl_pkt_cnt,
  output logic [31:0]                drop_pkt_cnt
);
  localparam int DW       = C_S_AXIS_DATA_WIDTH;
  localparam int KW       = DW / 8;
  localparam int UW       = C_S_AXIS_TUSER_WIDTH;
  localparam int NUM_OUT  = 2;
  localparam int OUT_DATA = 0;
  localparam int OUT_CTRL = 1;

  typedef enum logic [1:0] {IDLE, FWD_DATA, FWD_CTRL, DROP} state_t;

  state_t state, state_nxt, dest;

  logic [NUM_OUT-1:0][DW-1:0] o_tdata;
  logic [NUM_OUT-1:0][KW-1:0] o_tkeep;
  logic [NUM_OUT-1:0][UW-1:0] o_tuser;
  logic [NUM_OUT-1:0]         o_tlast, o_tvalid, o_tready, can_acc, load;

  // First-beat header decode (byte n = tdata[8n+7:8n])
  logic        tpid_ok, eth_ok, proto_ok, port_ok, is_ctrl, runt, accept;
  logic [15:0] dport;

  assign tpid_ok  = s_axis.tdata[8*12 +: 8] == 8'h81 && s_axis.tdata[8*13 +: 8] == 8'h00;
  assign eth_ok   = s_axis.tdata[8*16 +: 8] == 8'h08 && s_axis.tdata[8*17 +: 8] == 8'h00;
  assign proto_ok = s_axis.tdata[8*27 +: 8] == 8'h11;
  assign dport    = {s_axis.tdata[8*40 +: 8], s_axis.tdata[8*41 +: 8]};
  assign port_ok  = dport == CTRL_UDP_PORT;
  assign is_ctrl  = tpid_ok & eth_ok & proto_ok & port_ok;
  // A first beat too short to hold the UDP port is discarded outright.
  assign runt     = !s_axis.tkeep[41];
  assign accept   = s_axis.tvalid & s_axis.tready;

  // Destination of the beat on the input: classified in IDLE, latched after.
  always_comb begin
    dest = state;
    if (state == IDLE) begin
      if (runt)                   dest = DROP;
      else if (is_ctrl && !ctrl_en) dest = DROP;
      else if (is_ctrl)           dest = FWD_CTRL;
      else                        dest = FWD_DATA;
    end
  end

  // Next state and ingress ready; a first beat needs both outputs free
  // because its destination is not known until it is decoded.
  always_comb begin
    state_nxt     = state;
    s_axis.tready = 1'b0;
    case (state)
      IDLE:     s_axis.tready = can_acc[OUT_DATA] & can_acc[OUT_CTRL];
      FWD_DATA: s_axis.tready = can_acc[OUT_DATA];
      FWD_CTRL: s_axis.tready = can_acc[OUT_CTRL];
      DROP:     s_axis.tready = 1'b1;
      default:  s_axis.tready = 1'b0;
    endcase
    if (rst) s_axis.tready = 1'b0;
    if (accept) state_nxt = s_axis.tlast ? IDLE : dest;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Per-class packet counters, bumped on the accepted first beat
  always_ff @(posedge clk) begin
    if (rst) begin
      data_pkt_cnt <= '0;
      ctrl_pkt_cnt <= '0;
      drop_pkt_cnt <= '0;
    end else if (accept && state == IDLE) begin
      case (dest)
        FWD_DATA: data_pkt_cnt <= data_pkt_cnt + 32'd1;
        FWD_CTRL: ctrl_pkt_cnt <= ctrl_pkt_cnt + 32'd1;
        default:  drop_pkt_cnt <= drop_pkt_cnt + 32'd1;
      endcase
    end
  end

  assign load[OUT_DATA] = accept && dest == FWD_DATA;
  assign load[OUT_CTRL] = accept && dest == FWD_CTRL;
  assign o_tready       = {m_ctrl_axis.tready, m_data_axis.tready};

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    rmt_ingress_demux_ostage #(.DW(DW), .UW(UW)) u_ostage (
      .clk        (clk),
      .rst        (rst),
      .load       (load[g]),
      .in_tdata   (s_axis.tdata),
      .in_tkeep   (s_axis.tkeep),
      .in_tuser   (s_axis.tuser),
      .in_tlast   (s_axis.tlast),
      .out_tready (o_tready[g]),
      .out_tdata  (o_tdata[g]),
      .out_tkeep  (o_tkeep[g]),
      .out_tuser  (o_tuser[g]),
      .out_tlast  (o_tlast[g]),
      .out_tvalid (o_tvalid[g]),
      .can_acc    (can_acc[g])
    );
  end

  assign m_data_axis.tdata  = o_tdata[OUT_DATA];
  assign m_data_axis.tkeep  = o_tkeep[OUT_DATA];
  assign m_data_axis.tuser  = o_tuser[OUT_DATA];
  assign m_data_axis.tlast  = o_tlast[OUT_DATA];
  assign m_data_axis.tvalid = o_tvalid[OUT_DATA];
  assign m_ctrl_axis.tdata  = o_tdata[OUT_CTRL];
  assign m_ctrl_axis.tkeep  = o_tkeep[OUT_CTRL];
  assign m_ctrl_axis.tuser  = o_tuser[OUT_CTRL];
  assign m_ctrl_axis.tlast  = o_tlast[OUT_CTRL];
  assign m_ctrl_axis.tvalid = o_tvalid[OUT_CTRL];
endmodule

// File: tb/tb_rmt_ingress_demux.sv
// Directed bench for rmt_ingress_demux: classification, drop paths,
// back-pressure, back-to-back packets and reset mid-packet.
module tb_rmt_ingress_demux;
  logic clk = 1'b0;
  logic rst, ctrl_en;
  logic [31:0] data_pkt_cnt, ctrl_pkt_cnt, drop_pkt_cnt;
  int n_vec = 0;
  int n_err = 0;

  rmt_ingress_demux_if s_if ();
  rmt_ingress_demux_if d_if ();
  rmt_ingress_demux_if c_if ();

  always #5 clk = ~clk;

  rmt_ingress_demux dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_en      (ctrl_en),
    .s_axis       (s_if),
    .m_data_axis  (d_if),
    .m_ctrl_axis  (c_if),
    .data_pkt_cnt (data_pkt_cnt),
    .ctrl_pkt_cnt (ctrl_pkt_cnt),
    .drop_pkt_cnt (drop_pkt_cnt)
  );

  localparam logic [63:0] K_ALL  = '1;
  localparam logic [63:0] K_RUNT = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] K_TAIL = 64'h0000_0000_000F_FFFF;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk(input logic [15:0] tpid, input logic [15:0] eth,
                                      input logic [7:0] proto, input logic [15:0] dport,
                                      input logic [11:0] vid, input logic [7:0] seed);
    logic [511:0] d;
    for (int n = 0; n < 64; n++) d[8*n +: 8] = seed + 8'(n);
    d[8*12 +: 8] = tpid[15:8];
    d[8*13 +: 8] = tpid[7:0];
    d[8*14 +: 8] = {4'h0, vid[11:8]};
    d[8*15 +: 8] = vid[7:0];
    d[8*16 +: 8] = eth[15:8];
    d[8*17 +: 8] = eth[7:0];
    d[8*27 +: 8] = proto;
    d[8*40 +: 8] = dport[15:8];
    d[8*41 +: 8] = dport[7:0];
    return d;
  endfunction

  function automatic logic [127:0] usr(input logic [511:0] d);
    return {d[31:0], ~d[31:0], d[63:32], 32'hC0DE_0000};
  endfunction

  task automatic drive(input logic [511:0] d, input logic [63:0] k, input logic l);
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tuser  = usr(d);
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
  endtask

  task automatic idle_in();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [511:0] d1, d2, d3, c1, c2, r1, e1, e2, b0, b1, b2;

  initial begin
    d1 = mk(16'h8100, 16'h0800, 8'h11, 16'h10E1, 12'd1,  8'h10);
    c1 = mk(16'h8100, 16'h0800, 8'h11, 16'hF1F2, 12'd15, 8'h20);
    c2 = mk(16'h0000, 16'h0000, 8'h00, 16'h0000, 12'd0,  8'h30);
    r1 = mk(16'h8100, 16'h0800, 8'h11, 16'hF1F2, 12'd15, 8'h40);
    d2 = mk(16'h8100, 16'h0800, 8'h11, 16'h10E1, 12'd2,  8'h50);
    e1 = mk(16'h8100, 16'h0800, 8'h06, 16'hF1F2, 12'd3,  8'h60);
    e2 = mk(16'h88A8, 16'h0800, 8'h11, 16'hF1F2, 12'd4,  8'h70);
    b0 = mk(16'h8100, 16'h0800, 8'h11, 16'h1234, 12'd5,  8'h80);
    b1 = mk(16'h0000, 16'h0000, 8'h00, 16'h0000, 12'd0,  8'h90);
    b2 = mk(16'h0000, 16'h0000, 8'h00, 16'h0000, 12'd0,  8'hA0);
    d3 = mk(16'h8100, 16'h0800, 8'h11, 16'h10E1, 12'd6,  8'hB0);

    // Reset state
    rst = 1'b1; ctrl_en = 1'b1;
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
    d_if.tready = 1'b1; c_if.tready = 1'b1;
    tick(); tick();
    chk("rst_s_tready", 1'(s_if.tready), 1'b0);
    chk("rst_d_tvalid", 1'(d_if.tvalid), 1'b0);
    chk("rst_c_tvalid", 1'(c_if.tvalid), 1'b0);
    chk("rst_d_tdata", d_if.tdata, '0);
    chk("rst_cnts", {data_pkt_cnt, ctrl_pkt_cnt, drop_pkt_cnt}, '0);
    rst = 1'b0;
    tick();

    // Single-beat data packet
    drive(d1, K_ALL, 1'b1);
    #1 chk("t1_s_tready", 1'(s_if.tready), 1'b1);
    tick(); idle_in();
    chk("t1_d_tvalid", 1'(d_if.tvalid), 1'b1);
    chk("t1_d_tdata", d_if.tdata, d1);
    chk("t1_d_tkeep", d_if.tkeep, K_ALL);
    chk("t1_d_tuser", d_if.tuser, usr(d1));
    chk("t1_d_tlast", 1'(d_if.tlast), 1'b1);
    chk("t1_c_tvalid", 1'(c_if.tvalid), 1'b0);
    chk("t1_data_cnt", data_pkt_cnt, 32'd1);
    tick();
    chk("t1_d_drained", 1'(d_if.tvalid), 1'b0);

    // Two-beat control packet
    drive(c1, K_ALL, 1'b0);
    tick();
    chk("t2_c_tvalid0", 1'(c_if.tvalid), 1'b1);
    chk("t2_c_tdata0", c_if.tdata, c1);
    chk("t2_c_tlast0", 1'(c_if.tlast), 1'b0);
    chk("t2_d_tvalid0", 1'(d_if.tvalid), 1'b0);
    drive(c2, K_TAIL, 1'b1);
    #1 chk("t2_s_tready1", 1'(s_if.tready), 1'b1);
    tick(); idle_in();
    chk("t2_c_tdata1", c_if.tdata, c2);
    chk("t2_c_tkeep1", c_if.tkeep, K_TAIL);
    chk("t2_c_tuser1", c_if.tuser, usr(c2));
    chk("t2_c_tlast1", 1'(c_if.tlast), 1'b1);
    chk("t2_ctrl_cnt", ctrl_pkt_cnt, 32'd1);
    tick();

    // Control packet with ctrl_en low is dropped
    ctrl_en = 1'b0;
    drive(c1, K_ALL, 1'b0);
    #1 chk("t3_s_tready0", 1'(s_if.tready), 1'b1);
    tick();
    chk("t3_valids0", {1'(c_if.tvalid), 1'(d_if.tvalid)}, 2'b00);
    chk("t3_drop_cnt", drop_pkt_cnt, 32'd1);
    ctrl_en = 1'b1;   // mid-packet change must not matter
    drive(c2, K_TAIL, 1'b1);
    #1 chk("t3_s_tready1", 1'(s_if.tready), 1'b1);
    tick(); idle_in();
    chk("t3_valids1", {1'(c_if.tvalid), 1'(d_if.tvalid)}, 2'b00);
    chk("t3_ctrl_cnt", ctrl_pkt_cnt, 32'd1);

    // Runt with a control header: runt check wins, then a normal data packet
    drive(r1, K_RUNT, 1'b1);
    tick();
    chk("t4_runt_valids", {1'(c_if.tvalid), 1'(d_if.tvalid)}, 2'b00);
    chk("t4_drop_cnt", drop_pkt_cnt, 32'd2);
    chk("t4_ctrl_cnt", ctrl_pkt_cnt, 32'd1);
    drive(d2, K_ALL, 1'b1);
    tick();
    chk("t4_d2_tdata", d_if.tdata, d2);
    chk("t4_d2_tvalid", 1'(d_if.tvalid), 1'b1);
    // Back-to-back near-miss headers both go to data
    drive(e1, K_ALL, 1'b1);
    #1 chk("t4_b2b_tready", 1'(s_if.tready), 1'b1);
    tick();
    chk("t4_e1_tdata", d_if.tdata, e1);
    drive(e2, K_ALL, 1'b1);
    tick(); idle_in();
    chk("t4_e2_tdata", d_if.tdata, e2);
    chk("t4_c_tvalid", 1'(c_if.tvalid), 1'b0);
    chk("t4_data_cnt", data_pkt_cnt, 32'd4);

    // Back-pressure: m_data tready 1,0,0,1 over a 3-beat packet
    drive(b0, K_ALL, 1'b0);
    tick();
    chk("t5_a_tdata", d_if.tdata, b0);
    d_if.tready = 1'b0;
    drive(b1, K_ALL, 1'b0);
    #1 chk("t5_b_s_tready", 1'(s_if.tready), 1'b0);
    tick();
    chk("t5_b_hold", d_if.tdata, b0);
    chk("t5_b_tvalid", 1'(d_if.tvalid), 1'b1);
    #1 chk("t5_c_s_tready", 1'(s_if.tready), 1'b0);
    tick();
    chk("t5_c_hold", d_if.tdata, b0);
    d_if.tready = 1'b1;
    #1 chk("t5_d_s_tready", 1'(s_if.tready), 1'b1);
    tick();
    chk("t5_d_tdata", d_if.tdata, b1);
    chk("t5_d_tvalid", 1'(d_if.tvalid), 1'b1);
    drive(b2, K_ALL, 1'b1);
    tick(); idle_in();
    chk("t5_e_tdata", d_if.tdata, b2);
    chk("t5_e_tlast", 1'(d_if.tlast), 1'b1);
    chk("t5_data_cnt", data_pkt_cnt, 32'd5);
    tick();
    chk("t5_drained", 1'(d_if.tvalid), 1'b0);

    // Reset after beat 1 of a 3-beat control packet, then a data packet
    drive(c1, K_ALL, 1'b0);
    tick(); idle_in();
    chk("t6_c_loaded", 1'(c_if.tvalid), 1'b1);
    rst = 1'b1;
    tick();
    chk("t6_rst_s_tready", 1'(s_if.tready), 1'b0);
    rst = 1'b0;
    chk("t6_c_tvalid", 1'(c_if.tvalid), 1'b0);
    chk("t6_c_tdata", c_if.tdata, '0);
    chk("t6_cnts", {data_pkt_cnt, ctrl_pkt_cnt, drop_pkt_cnt}, '0);
    drive(d3, K_ALL, 1'b1);
    tick(); idle_in();
    chk("t6_d_tvalid", 1'(d_if.tvalid), 1'b1);
    chk("t6_d_tdata", d_if.tdata, d3);
    chk("t6_c_tvalid2", 1'(c_if.tvalid), 1'b0);
    chk("t6_data_cnt", data_pkt_cnt, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rmt_ingress_demux.md
# rmt_ingress_demux

Ingress stage placed directly upstream of `rmt_wrapper`. It inspects the first beat of every 512-bit AXI-Stream packet and steers the whole packet to one of three places: the data output that feeds the RMT pipeline, the control output that feeds the table/stateful configuration path, or a drop sink. Control packets are VLAN-tagged IPv4/UDP frames with UDP destination port 0xF1F2. Per-class 32-bit packet counters are exported for debug.

## Interface
- `C_S_AXIS_DATA_WIDTH`, default 512: stream data width. Fixed at 512; header offsets below assume it.
- `C_S_AXIS_TUSER_WIDTH`, default 128: tuser width. Passed through unchanged.
- `CTRL_UDP_PORT`, default 16'hF1F2: UDP destination port that marks a control packet.
- `clk`, input, 1: single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `ctrl_en`, input, 1: when low, control packets are dropped. Sampled on the first beat only.
- `s_axis_tdata`, `s_axis_tkeep`, `s_axis_tuser`, `s_axis_tvalid`, `s_axis_tlast`, input, 512/64/128/1/1: ingress stream.
- `s_axis_tready`, output, 1: ingress ready.
- `m_data_axis_{tdata,tkeep,tuser,tvalid,tlast}`, output, 512/64/128/1/1: to the RMT pipeline.
- `m_data_axis_tready`, input, 1.
- `m_ctrl_axis_{tdata,tkeep,tuser,tvalid,tlast}`, output, 512/64/128/1/1: to the config path.
- `m_ctrl_axis_tready`, input, 1.
- `data_pkt_cnt`, `ctrl_pkt_cnt`, `drop_pkt_cnt`, output, 32 each: packet counters.

## Operation
- Byte n of a beat is `tdata[8n+7:8n]`.
- Header fields on the first beat:
  - TPID: bytes 12–13 must equal 0x81,0x00.
  - Ethertype: bytes 16–17 must equal 0x08,0x00.
  - IP protocol: byte 27 must equal 0x11.
  - UDP destination port: bytes 40–41, big-endian.
- `is_ctrl` = TPID match & ethertype match & protocol match & dst port == `CTRL_UDP_PORT`.
- Runt: a first beat with `tkeep[41]==0` is dropped. This check has priority over classification.
- FSM states:
  - IDLE: waiting for a first beat.
  - FWD_DATA, FWD_CTRL: forwarding the current packet to one output.
  - DROP: consuming and discarding the current packet.
- IDLE transitions, taken when a first beat is accepted:
  - runt → DROP
  - `is_ctrl` & !`ctrl_en` → DROP
  - `is_ctrl` & `ctrl_en` → FWD_CTRL
  - otherwise → FWD_DATA
- A single-beat packet (tlast on the first beat) is forwarded or dropped and the FSM stays in IDLE.
- FWD_*/DROP return to IDLE on the accepted beat that has tlast=1.
- The class is latched for the whole packet. Later beats are never inspected, and a `ctrl_en` change mid-packet has no effect.
- Each output has a one-entry register stage. It loads when the input beat is accepted for that output, and holds its contents while its tvalid=1 and tready=0.
- Counters:
  - Each increments by 1 when the first beat of a packet is accepted, according to the class chosen.
  - All wrap from 0xFFFFFFFF to 0.
- tdata, tkeep, tuser and tlast pass through unmodified.

## Timing
- Reset values:
  - All tvalid outputs 0; all output tdata/tkeep/tuser/tlast 0.
  - FSM in IDLE; all counters 0; `s_axis_tready` 0 during reset.
- Latency: an accepted beat appears on its output on the next cycle.
- Output stage ready: `*_can_acc = !m_*_tvalid | m_*_tready`.
- `s_axis_tready` by state:
  - IDLE: `data_can_acc & ctrl_can_acc`.
  - FWD_DATA: `data_can_acc`.
  - FWD_CTRL: `ctrl_can_acc`.
  - DROP: 1.
- Full throughput: one beat per cycle while the downstream holds tready=1.
- Back-to-back packets: a new first beat is accepted on the cycle after the previous tlast beat, with no bubble.
- AXIS compliance: output tvalid never drops without a handshake, and output data is stable while tvalid=1 and tready=0.
- Simultaneous load and drain of an output register in the same cycle keeps tvalid=1 with the new beat.
- Reset mid-packet:
  - All output registers are flushed and any in-flight beat is lost.
  - The FSM returns to IDLE, so the next beat seen is treated as a first beat.
- Input tvalid=0 mid-packet holds state; no timeout.

## Test plan
- Data packet:
  - Stimulus: VLAN 1, UDP dst 0x10E1, 1 beat, tkeep all-ones, tlast=1.
  - Required: identical beat on `m_data` one cycle later; `data_pkt_cnt`=1; `m_ctrl_axis_tvalid` stays 0.
- Control packet:
  - Stimulus: 2-beat packet with UDP dst 0xF1F2, VLAN 15, second beat tkeep 0x00000000000FFFFF, `ctrl_en`=1.
  - Required: both beats on `m_ctrl` in order, tlast on the 2nd beat, unmodified; `ctrl_pkt_cnt`=1.
- Control packet with `ctrl_en`=0:
  - Required: `s_axis_tready` stays 1; neither output asserts tvalid; `drop_pkt_cnt`=1.
- Runt:
  - Stimulus: first beat with tkeep=0x000000000000FFFF and tlast=1.
  - Required: dropped; `drop_pkt_cnt`=1.
  - Stimulus: the next valid data packet.
  - Required: forwarded normally.
- Back-pressure:
  - Stimulus: `m_data_axis_tready` toggled 1,0,0,1 during a 3-beat data packet.
  - Required: no beat lost or duplicated; output data stable while stalled; `s_axis_tready` deasserted while the output register is full.
- Reset mid-packet:
  - Stimulus: assert `rst` for 1 cycle after beat 1 of a 3-beat control packet, then send a data packet.
  - Required: outputs and counters are 0 after reset; the data packet goes to `m_data` with `data_pkt_cnt`=1.
